mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised successor to the lab0 4-bit free-running counter: WIDTH-bit up/down counter with programmable modulus, enable, synchronous clear/load, optional saturation and an input prescaler.
- Generic timing/indexing primitive for later labs: pixel/weight address generation, neuron-layer sequencing, display refresh dividers.
- One-cycle overflow pulse lets counters be cascaded (ovf of stage N drives en of stage N+1).

Parameters:
- WIDTH, 4, counter width in bits (>=1).
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX, requires MAX <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.
- PRESCALE, 1, counter steps once per PRESCALE enabled cycles (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; gates both prescaler and counter.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- ovf  out  1  registered one-cycle pulse on wrap or saturation hit.
- at_max  out  1  combinational, count == MAX.
- at_min  out  1  combinational, count == 0.

Behaviour:
- Reset (reset low, asynchronous, no clock needed): count=0, ovf=0, prescaler phase=0; at_max/at_min follow count (at_min=1; at_max=1 only if MAX==0).
- Priority each rising edge: clear > load > step > hold.
- clear: count<=0, prescaler phase<=0, ovf<=0.
- load: count<=min(load_val, MAX) (values above MAX clamp to MAX), phase<=0, ovf<=0.
- Prescaler: internal phase counter 0..PRESCALE-1, width clog2(PRESCALE) (min 1 bit). When en=1: tick=1 if phase==PRESCALE-1, phase<=phase+1 wrapping to 0. When en=0: phase holds, tick=0. PRESCALE=1: tick=en, phase unused.
- Step (tick=1, no clear/load), ovf is registered in the same edge as the count update:
  - up=1, count<MAX: count+1, ovf<=0.
  - up=1, count==MAX: SATURATE=0 -> count<=0, ovf<=1; SATURATE=1 -> hold MAX, ovf<=1.
  - up=0, count>0: count-1, ovf<=0.
  - up=0, count==0: SATURATE=0 -> count<=MAX, ovf<=1; SATURATE=1 -> hold 0, ovf<=1.
- No step: count holds, ovf<=0 (ovf never stays high more than one cycle unless boundary is re-hit on consecutive ticks, e.g. saturated with PRESCALE=1).
- Latency: count changes one edge after the qualifying inputs; at_max/at_min are valid the same cycle count is.
- Arithmetic: compare before add/sub; no intermediate exceeds WIDTH bits; MAX not a power of two must wrap exactly at MAX, never at 2**WIDTH-1.
- Direction change mid-count takes effect on the next tick; it does not reset phase.
- Reset asserted mid-operation overrides all, including a pending tick; counting resumes from 0 with phase 0 on the first edge after reset deasserts.

Decomposition:
- Shared package: clog2 function and SAT_WRAP=0 / SAT_HOLD=1 constants for the SATURATE parameter.
- One sub-module: tick_prescaler (params PRESCALE; ports clk, reset, en, restart, tick), holding the phase counter; restart driven by clear|load.

Test Plan:
- Reset/default: WIDTH=4, MAX=15, en=1, up=1, 20 cycles -> count 0..15,0..3; ovf high exactly on the edge count goes 15->0; at_min=1 out of reset.
- Modulo + down: MAX=9, up=0 from 0 -> count 9,8..0,9; ovf on each 0->9 transition; at_max=1 only while count=9.
- Saturate: SATURATE=1, MAX=9, load_val=7, up=1, en=1 for 5 cycles -> 8,9,9,9; ovf high on every tick at 9; flip up=0 -> 8.
- Priority/clamp: load_val=12 with MAX=9 -> count=9; clear and load both high with load_val=5 -> count=0; load with en=0 still loads.
- Prescaler: PRESCALE=3, en=1 -> count increments every 3rd edge; drop en for 2 cycles mid-phase -> phase resumes, no lost or extra step; load mid-phase restarts the 3-cycle window.
- Async reset: assert reset low between clock edges at count=6 -> count=0 and ovf=0 immediately, no clock required; release -> first step after PRESCALE enabled cycles.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared definitions for mod_counter: the saturation-mode constants and a
// constant-foldable ceiling log2 used to size the prescaler phase register.
package mod_counter_pkg;

   localparam int SAT_WRAP = 0;
   localparam int SAT_HOLD = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: raises tick on every PRESCALE-th enabled cycle. The phase
// holds while en is low and returns to 0 on restart.
module tick_prescaler
   import mod_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tick
);

   // With PRESCALE == 1 the phase stays pinned at 0, so tick reduces to en.
   localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;

   assign tick = en && (phase == LAST);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (restart) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST) ? '0 : phase + PW'(1);
      end
   end

endmodule

// File: rtl/mod_counter.sv
// WIDTH-bit up/down modulo counter with enable, clear/load, optional saturation,
// input prescaler and a one-cycle ovf pulse for cascading.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX      = 2**WIDTH - 1,
   parameter int SATURATE = SAT_WRAP,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic             tick;
   logic [WIDTH-1:0] count_d;
   logic             ovf_d;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .restart (clear | load),
      .tick    (tick)
   );

   assign at_max = (count == MAX_V);
   assign at_min = (count == '0);

   // Boundaries are compared before stepping so nothing ever exceeds WIDTH bits
   // and a non-power-of-two MAX wraps exactly at MAX.
   always_comb begin
      // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
      count_d = count;
      ovf_d   = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (tick) begin
         if (up) begin
            if (count == MAX_V) begin
               count_d = (SATURATE == SAT_HOLD) ? MAX_V : '0;
               ovf_d   = 1'b1;
            end else begin
               count_d = count + ONE;
            end
         end else begin
            if (count == '0) begin
               count_d = (SATURATE == SAT_HOLD) ? '0 : MAX_V;
               ovf_d   = 1'b1;
            end else begin
               count_d = count - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         count <= count_d;
         ovf   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: four instances (default, modulo-10 wrap,
// modulo-10 saturating, prescale-3) share one stimulus stream.
module tb_mod_counter;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up;
   logic       clear;
   logic       load;
   logic [3:0] load_val;

   logic [3:0] d_count, m_count, s_count, p_count;
   logic       d_ovf, m_ovf, s_ovf, p_ovf;
   logic       d_at_max, m_at_max, s_at_max, p_at_max;
   logic       d_at_min, m_at_min, s_at_min, p_at_min;

   int checks = 0;
   int passes = 0;

   mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(0), .PRESCALE(1)) u_def (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(d_count), .ovf(d_ovf), .at_max(d_at_max), .at_min(d_at_min));

   mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(1)) u_mod (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(m_count), .ovf(m_ovf), .at_max(m_at_max), .at_min(m_at_min));

   mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1), .PRESCALE(1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(s_count), .ovf(s_ovf), .at_max(s_at_max), .at_min(s_at_min));

   mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(0), .PRESCALE(3)) u_pre (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(p_count), .ovf(p_ovf), .at_max(p_at_max), .at_min(p_at_min));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_count;

      reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;

      // Reset state
      #2;
      check("rst_count", d_count, 0);
      check("rst_ovf", d_ovf, 0);
      check("rst_at_min", d_at_min, 1);
      check("rst_at_max", d_at_max, 0);
      @(posedge clk);
      #1;
      reset = 1'b1; en = 1'b1; up = 1'b1;

      // Default free-running count 0..15,0..3
      for (int i = 1; i <= 20; i++) begin
         step();
         exp_count = i % 16;
         check($sformatf("def_count_%0d", i), d_count, exp_count);
         check($sformatf("def_ovf_%0d", i), d_ovf, (i == 16) ? 1 : 0);
         check($sformatf("def_at_max_%0d", i), d_at_max, (exp_count == 15) ? 1 : 0);
      end

      // Modulo-10 counting down from 0
      clear = 1'b1;
      step();
      check("mod_clear", m_count, 0);
      clear = 1'b0; up = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         step();
         exp_count = (10 - (i % 10)) % 10;
         check($sformatf("mod_dn_count_%0d", i), m_count, exp_count);
         check($sformatf("mod_dn_ovf_%0d", i), m_ovf, (i == 1 || i == 11) ? 1 : 0);
         check($sformatf("mod_dn_at_max_%0d", i), m_at_max, (exp_count == 9) ? 1 : 0);
      end

      // Saturation at MAX=9, then direction flip
      load = 1'b1; load_val = 4'd7; up = 1'b1;
      step();
      check("sat_load", s_count, 7);
      check("sat_load_ovf", s_ovf, 0);
      load = 1'b0;
      step(); check("sat_c1", s_count, 8); check("sat_o1", s_ovf, 0);
      step(); check("sat_c2", s_count, 9); check("sat_o2", s_ovf, 0);
      step(); check("sat_c3", s_count, 9); check("sat_o3", s_ovf, 1);
      step(); check("sat_c4", s_count, 9); check("sat_o4", s_ovf, 1);
      step(); check("sat_c5", s_count, 9); check("sat_o5", s_ovf, 1);
      up = 1'b0;
      step(); check("sat_flip", s_count, 8); check("sat_flip_ovf", s_ovf, 0);

      // Priority and clamping
      load = 1'b1; load_val = 4'd12;
      step();
      check("clamp_sat", s_count, 9);
      check("clamp_mod", m_count, 9);
      check("clamp_def", d_count, 12);
      clear = 1'b1; load_val = 4'd5;
      step();
      check("clear_over_load", s_count, 0);
      clear = 1'b0; en = 1'b0;
      step();
      check("load_no_en", s_count, 5);
      load = 1'b0;
      step();
      check("hold_no_en", s_count, 5);
      check("hold_no_en_ovf", s_ovf, 0);

      // Modulo-10 counting up wraps at 9, not 15
      en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd8;
      step();
      check("mod_up_load", m_count, 8);
      load = 1'b0;
      step(); check("mod_up_9", m_count, 9); check("mod_up_at_max", m_at_max, 1);
      step(); check("mod_up_wrap", m_count, 0); check("mod_up_ovf", m_ovf, 1);
      step(); check("mod_up_1", m_count, 1); check("mod_up_ovf_clr", m_ovf, 0);

      // Prescale by 3, with an enable gap and a mid-phase load
      clear = 1'b1;
      step();
      check("pre_clear", p_count, 0);
      clear = 1'b0;
      step(); check("pre_e1", p_count, 0);
      step(); check("pre_e2", p_count, 0);
      step(); check("pre_e3", p_count, 1);
      step(); check("pre_e4", p_count, 1);
      en = 1'b0;
      step(); check("pre_gap1", p_count, 1);
      step(); check("pre_gap2", p_count, 1);
      en = 1'b1;
      step(); check("pre_e5", p_count, 1);
      step(); check("pre_e6", p_count, 2);
      step(); check("pre_e7", p_count, 2);
      load = 1'b1; load_val = 4'd4;
      step(); check("pre_load", p_count, 4);
      load = 1'b0;
      step(); check("pre_l1", p_count, 4);
      step(); check("pre_l2", p_count, 4);
      step(); check("pre_l3", p_count, 5);

      // Asynchronous reset between edges
      load = 1'b1; load_val = 4'd6;
      step();
      check("ar_pre_count", d_count, 6);
      load = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("ar_count", d_count, 0);
      check("ar_ovf", d_ovf, 0);
      check("ar_at_min", d_at_min, 1);
      check("ar_pre", p_count, 0);
      step();
      check("ar_hold", d_count, 0);
      reset = 1'b1; en = 1'b1; up = 1'b1;
      step(); check("ar_p1", p_count, 0); check("ar_d1", d_count, 1);
      step(); check("ar_p2", p_count, 0); check("ar_d2", d_count, 2);
      step(); check("ar_p3", p_count, 1); check("ar_d3", d_count, 3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
